lcd_spi_rx: RTL and testbench

- Receive-side model/monitor for the 4-wire LCD serial link: lcd_sel, lcd_dc, lcd_sda, lcd_sck.
- Oversamples the link in the 12 MHz system domain and assembles bytes, tagging each as command or data.
- Decodes the display command set and converts the RAMWR pixel stream into RGB565 pixels with x/y coordinates.
- Used as the display end in loopback benches and as an on-chip frame snoop for the spectrum display path.

---
 rtl/lcd_spi_rx.sv | 266 ++++++++++++++++++++++++++
 tb/tb_lcd_spi_rx.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx : receive-side monitor for the 4-wire LCD serial link.
//
// Oversamples lcd_sel / lcd_dc / lcd_sda / lcd_sck in the clk domain,
// assembles MSB-first bytes tagged as command/data, decodes the display
// command set (sleep, display on/off, CASET, PASET, RAMWR) and turns the
// RAMWR stream into RGB565 pixels with window coordinates.
//
// Optional build macro: LCD_RX_PIXCNT_EN
//   defined   -> pix_count counts pixels since the last accepted RAMWR
//                (saturating at 20'hFFFFF)
//   undefined -> no counter is built, pix_count is tied to 0
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   lcd_sel/dc/sda/sck  LCD link inputs (asynchronous to clk)
//   byte_valid/data/is_cmd  received byte, valid pulse + held data
//   pix_valid/data/x/y  pixel pulse + held pixel and coordinates
//   frame_done          pulse with the last pixel of the window
//   sleep_out, display_on  command-controlled levels
//   err_flag            sticky protocol error
//   pix_count           pixel counter (optional feature)
`timescale 1ns/1ps

module lcd_spi_rx #(
    parameter int LCD_WIDTH  = 240,
    parameter int LCD_HEIGHT = 320
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lcd_sel,
    input  logic        lcd_dc,
    input  logic        lcd_sda,
    input  logic        lcd_sck,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_is_cmd,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        frame_done,
    output logic        sleep_out,
    output logic        display_on,
    output logic        err_flag,
    output logic [19:0] pix_count
);

    localparam logic [9:0] W_LIM  = 10'(LCD_WIDTH);
    localparam logic [9:0] H_LIM  = 10'(LCD_HEIGHT);
    localparam logic [8:0] XE_DEF = 9'(LCD_WIDTH - 1);
    localparam logic [8:0] YE_DEF = 9'(LCD_HEIGHT - 1);

    // ------------------------------------------------------------------
    // Input synchronisers; third sck flop gives the rising-edge detect
    // ------------------------------------------------------------------
    logic [1:0] sel_sync_q, dc_sync_q, sda_sync_q;
    logic [2:0] sck_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_sync_q <= 2'b11;          // idle as deselected
            dc_sync_q  <= 2'b00;
            sda_sync_q <= 2'b00;
            sck_sync_q <= 3'b000;
        end else begin
            sel_sync_q <= {sel_sync_q[0], lcd_sel};
            dc_sync_q  <= {dc_sync_q[0], lcd_dc};
            sda_sync_q <= {sda_sync_q[0], lcd_sda};
            sck_sync_q <= {sck_sync_q[1:0], lcd_sck};
        end
    end

    logic sel_s, dc_s, sda_s, sck_rise;
    assign sel_s    = sel_sync_q[1];
    assign dc_s     = dc_sync_q[1];
    assign sda_s    = sda_sync_q[1];
    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];

    // ------------------------------------------------------------------
    // Byte assembly
    // ------------------------------------------------------------------
    logic [6:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       byte_valid_q, byte_is_cmd_q;
    logic [7:0] byte_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            byte_valid_q  <= 1'b0;
            byte_data_q   <= '0;
            byte_is_cmd_q <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            if (sel_s) begin
                bit_cnt_q <= '0;          // partial byte is dropped
            end else if (sck_rise) begin
                shift_q   <= {shift_q[5:0], sda_s};
                bit_cnt_q <= bit_cnt_q + 3'd1;   // wraps to 0 after bit 8
                if (bit_cnt_q == 3'd7) begin
                    byte_data_q   <= {shift_q, sda_s};
                    byte_is_cmd_q <= ~dc_s;
                    byte_valid_q  <= 1'b1;
                end
            end
        end
    end

    assign byte_valid  = byte_valid_q;
    assign byte_data   = byte_data_q;
    assign byte_is_cmd = byte_is_cmd_q;

    // ------------------------------------------------------------------
    // Command decoder / pixel generator
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {S_IDLE, S_CASET, S_PASET, S_RAMWR} state_t;

    state_t      state_q;
    logic [1:0]  arg_idx_q;
    logic [23:0] arg_q;                   // first three argument bytes
    logic [8:0]  xs_q, xe_q, ys_q, ye_q;
    logic [8:0]  cur_x_q, cur_y_q;
    logic        hi_pend_q;               // high byte held, low byte next
    logic [7:0]  hi_q;
    logic        pix_valid_q, frame_done_q;
    logic [15:0] pix_data_q;
    logic [8:0]  pix_x_q, pix_y_q;
    logic        sleep_q, disp_q, err_q;

    logic cmd_ev, dat_ev, win_ok, ramwr_ok, pix_emit, x_last, y_last;
    assign cmd_ev   = byte_valid_q &  byte_is_cmd_q;
    assign dat_ev   = byte_valid_q & ~byte_is_cmd_q;
    assign win_ok   = (xs_q <= xe_q) && ({1'b0, xe_q} < W_LIM) &&
                      (ys_q <= ye_q) && ({1'b0, ye_q} < H_LIM);
    assign ramwr_ok = cmd_ev && (byte_data_q == 8'h2C) && win_ok;
    assign pix_emit = dat_ev && (state_q == S_RAMWR) && hi_pend_q;
    assign x_last   = (cur_x_q == xe_q);
    assign y_last   = (cur_y_q == ye_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            arg_idx_q    <= '0;
            arg_q        <= '0;
            xs_q         <= '0;
            xe_q         <= XE_DEF;
            ys_q         <= '0;
            ye_q         <= YE_DEF;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            hi_pend_q    <= 1'b0;
            hi_q         <= '0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pix_data_q   <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            sleep_q      <= 1'b0;
            disp_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (cmd_ev) begin
                // Any command aborts the current state first.
                if (state_q == S_RAMWR && hi_pend_q) err_q <= 1'b1;
                hi_pend_q <= 1'b0;
                arg_idx_q <= '0;
                state_q   <= S_IDLE;
                case (byte_data_q)
                    8'h11: sleep_q <= 1'b1;
                    8'h10: sleep_q <= 1'b0;
                    8'h29: disp_q  <= 1'b1;
                    8'h28: disp_q  <= 1'b0;
                    8'h2A: state_q <= S_CASET;
                    8'h2B: state_q <= S_PASET;
                    8'h2C: begin
                        if (win_ok) begin
                            cur_x_q <= xs_q;
                            cur_y_q <= ys_q;
                            state_q <= S_RAMWR;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (dat_ev) begin
                case (state_q)
                    S_CASET, S_PASET: begin
                        arg_idx_q <= arg_idx_q + 2'd1;
                        case (arg_idx_q)
                            2'd0: arg_q[23:16] <= byte_data_q;
                            2'd1: arg_q[15:8]  <= byte_data_q;
                            2'd2: arg_q[7:0]   <= byte_data_q;
                            default: begin
                                // 4th byte: commit start/end together
                                if (arg_q[23:17] != '0 || arg_q[7:1] != '0)
                                    err_q <= 1'b1;
                                if (state_q == S_CASET) begin
                                    xs_q <= arg_q[16:8];
                                    xe_q <= {arg_q[0], byte_data_q};
                                end else begin
                                    ys_q <= arg_q[16:8];
                                    ye_q <= {arg_q[0], byte_data_q};
                                end
                                state_q <= S_IDLE;
                            end
                        endcase
                    end
                    S_RAMWR: begin
                        if (!hi_pend_q) begin
                            hi_q      <= byte_data_q;
                            hi_pend_q <= 1'b1;
                        end else begin
                            hi_pend_q    <= 1'b0;
                            pix_valid_q  <= 1'b1;
                            pix_data_q   <= {hi_q, byte_data_q};
                            pix_x_q      <= cur_x_q;
                            pix_y_q      <= cur_y_q;
                            frame_done_q <= x_last && y_last;
                            if (x_last) begin
                                cur_x_q <= xs_q;
                                cur_y_q <= y_last ? ys_q : cur_y_q + 9'd1;
                            end else begin
                                cur_x_q <= cur_x_q + 9'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign frame_done = frame_done_q;
    assign sleep_out  = sleep_q;
    assign display_on = disp_q;
    assign err_flag   = err_q;

    // ------------------------------------------------------------------
    // Optional pixel counter
    // ------------------------------------------------------------------
`ifdef LCD_RX_PIXCNT_EN
    logic [19:0] pix_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pix_cnt_q <= '0;
        else if (ramwr_ok)
            pix_cnt_q <= '0;
        else if (pix_emit && pix_cnt_q != 20'hFFFFF)
            pix_cnt_q <= pix_cnt_q + 20'd1;
    end

    assign pix_count = pix_cnt_q;
`else
    assign pix_count = '0;
`endif

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Testbench for lcd_spi_rx: directed link traffic, a queue-based reference
// model of bytes/pixels, one monitor comparing every output pulse, plus
// literal expectations on key points.
`timescale 1ns/1ps

module tb_lcd_spi_rx;

    logic clk = 1'b0, rst_n = 1'b0;
    logic lcd_sel = 1'b1, lcd_dc = 1'b0, lcd_sda = 1'b0, lcd_sck = 1'b0;
    logic        byte_valid, byte_is_cmd, pix_valid, frame_done;
    logic        sleep_out, display_on, err_flag;
    logic [7:0]  byte_data;
    logic [15:0] pix_data;
    logic [8:0]  pix_x, pix_y;
    logic [19:0] pix_count;

    lcd_spi_rx dut (
        .clk(clk), .rst_n(rst_n),
        .lcd_sel(lcd_sel), .lcd_dc(lcd_dc), .lcd_sda(lcd_sda), .lcd_sck(lcd_sck),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_cmd(byte_is_cmd),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .frame_done(frame_done), .sleep_out(sleep_out), .display_on(display_on),
        .err_flag(err_flag), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; logic [15:0] d; bit fd; } pix_t;

    int checks = 0, errors = 0;

    // reference model state
    logic [8:0] exp_b[$];               // {is_cmd, data}
    pix_t       exp_p[$];
    pix_t       px_log[$];              // pixels seen from the DUT
    logic [8:0] by_log[$];              // bytes seen from the DUT
    int   m_mode, m_nargs, m_pix_n, m_cnt;
    int   m_xs, m_xe, m_ys, m_ye;
    bit   m_sleep, m_disp, m_err, m_have_hi;
    logic [7:0] m_hi;
    int   m_args[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_nargs = 0; m_pix_n = 0; m_cnt = 0;
        m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319;
        m_sleep = 0; m_disp = 0; m_err = 0; m_have_hi = 0; m_hi = 0;
        exp_b.delete(); exp_p.delete();
    endtask

    // mode: 0 idle, 1 column args, 2 row args, 3 pixel stream
    task automatic model_byte(input bit dc, input logic [7:0] b);
        int s, e, w, h, idx;
        pix_t p;
        exp_b.push_back({~dc, b});
        if (!dc) begin
            if (m_mode == 3 && m_have_hi) m_err = 1;
            m_have_hi = 0;
            m_mode = 0;
            case (b)
                8'h11: m_sleep = 1;
                8'h10: m_sleep = 0;
                8'h29: m_disp = 1;
                8'h28: m_disp = 0;
                8'h2A: begin m_mode = 1; m_nargs = 0; end
                8'h2B: begin m_mode = 2; m_nargs = 0; end
                8'h2C: begin
                    if (m_xs <= m_xe && m_xe < 240 && m_ys <= m_ye && m_ye < 320) begin
                        m_mode = 3; m_pix_n = 0; m_cnt = 0;
                    end else m_err = 1;
                end
                default: ;
            endcase
        end else if (m_mode == 1 || m_mode == 2) begin
            m_args[m_nargs] = int'(b);
            m_nargs++;
            if (m_nargs == 4) begin
                s = m_args[0] * 256 + m_args[1];
                e = m_args[2] * 256 + m_args[3];
                if (s > 511 || e > 511) m_err = 1;
                if (m_mode == 1) begin m_xs = s % 512; m_xe = e % 512; end
                else             begin m_ys = s % 512; m_ye = e % 512; end
                m_mode = 0;
            end
        end else if (m_mode == 3) begin
            if (!m_have_hi) begin
                m_hi = b; m_have_hi = 1;
            end else begin
                m_have_hi = 0;
                w = m_xe - m_xs + 1;
                h = m_ye - m_ys + 1;
                idx = m_pix_n % (w * h);
                p.x = m_xs + idx % w;
                p.y = m_ys + idx / w;
                p.d = {m_hi, b};
                p.fd = (idx == w * h - 1);
                exp_p.push_back(p);
                m_pix_n++;
                if (m_cnt < 20'hFFFFF) m_cnt++;
            end
        end
    endtask

    // sck period 8 clk: 4 low, 4 high; sda changes while sck is low
    task automatic send_bits(input bit dc, input logic [7:0] b, input int nbits);
        @(negedge clk);
        lcd_dc = dc; lcd_sel = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 7; i > 7 - nbits; i--) begin
            lcd_sck = 1'b0; lcd_sda = b[i];
            repeat (4) @(negedge clk);
            lcd_sck = 1'b1;
            repeat (4) @(negedge clk);
        end
        lcd_sck = 1'b0;
    endtask

    task automatic send_byte(input bit dc, input logic [7:0] b);
        model_byte(dc, b);
        send_bits(dc, b, 8);
        repeat (4) @(negedge clk);
        lcd_sel = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic levels(input string tag);
        chk({tag, " sleep_out"}, 32'(sleep_out), 32'(m_sleep));
        chk({tag, " display_on"}, 32'(display_on), 32'(m_disp));
        chk({tag, " err_flag"}, 32'(err_flag), 32'(m_err));
`ifdef LCD_RX_PIXCNT_EN
        chk({tag, " pix_count"}, 32'(pix_count), 32'(m_cnt));
`else
        chk({tag, " pix_count"}, 32'(pix_count), 32'd0);
`endif
    endtask

    task automatic all_zero(input string tag);
        chk({tag, " byte_valid"}, 32'(byte_valid), 0);
        chk({tag, " byte_data"}, 32'(byte_data), 0);
        chk({tag, " byte_is_cmd"}, 32'(byte_is_cmd), 0);
        chk({tag, " pix_valid"}, 32'(pix_valid), 0);
        chk({tag, " pix_data"}, 32'(pix_data), 0);
        chk({tag, " pix_x"}, 32'(pix_x), 0);
        chk({tag, " pix_y"}, 32'(pix_y), 0);
        chk({tag, " frame_done"}, 32'(frame_done), 0);
        chk({tag, " sleep_out"}, 32'(sleep_out), 0);
        chk({tag, " display_on"}, 32'(display_on), 0);
        chk({tag, " err_flag"}, 32'(err_flag), 0);
        chk({tag, " pix_count"}, 32'(pix_count), 0);
    endtask

    task automatic monitor();
        logic [8:0] eb;
        pix_t ep, got;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (byte_valid) begin
                    by_log.push_back({byte_is_cmd, byte_data});
                    if (exp_b.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL byte: got unexpected %0h expected none", {byte_is_cmd, byte_data});
                    end else begin
                        eb = exp_b.pop_front();
                        chk("byte", 32'({byte_is_cmd, byte_data}), 32'(eb));
                    end
                end
                if (pix_valid) begin
                    got.x = int'(pix_x); got.y = int'(pix_y); got.d = pix_data; got.fd = frame_done;
                    px_log.push_back(got);
                    if (exp_p.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL pixel: got unexpected %0h at (%0d,%0d) expected none", pix_data, pix_x, pix_y);
                    end else begin
                        ep = exp_p.pop_front();
                        chk("pix_x", 32'(pix_x), 32'(ep.x));
                        chk("pix_y", 32'(pix_y), 32'(ep.y));
                        chk("pix_data", 32'(pix_data), 32'(ep.d));
                        chk("frame_done", 32'(frame_done), 32'(ep.fd));
                    end
                end else if (frame_done) begin
                    checks++; errors++;
                    $display("FAIL frame_done: got 1 without pix_valid expected 0");
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; lcd_sel = 1'b1; lcd_sck = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int np;
        logic [7:0] seq[8];
        model_reset();
        fork monitor(); join_none

        // reset state
        repeat (3) @(negedge clk);
        all_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // sleep out, display on
        send_byte(0, 8'h11);
        repeat (10) @(negedge clk);
        send_byte(0, 8'h29);
        levels("power");
        chk("lit sleep_out", 32'(sleep_out), 1);
        chk("lit display_on", 32'(display_on), 1);
        chk("lit err_flag", 32'(err_flag), 0);
        chk("lit byte0", 32'(by_log[0]), 32'h111);
        chk("lit byte1", 32'(by_log[1]), 32'h129);

        // 2x2 window at (10..11, 5..6), four pixels
        send_byte(0, 8'h2A);
        send_byte(1, 8'h00); send_byte(1, 8'h0A); send_byte(1, 8'h00); send_byte(1, 8'h0B);
        send_byte(0, 8'h2B);
        send_byte(1, 8'h00); send_byte(1, 8'h05); send_byte(1, 8'h00); send_byte(1, 8'h06);
        send_byte(0, 8'h2C);
        seq = '{8'hF8, 8'h00, 8'hFF, 8'hE0, 8'h07, 8'hE0, 8'h00, 8'h1F};
        foreach (seq[i]) send_byte(1, seq[i]);
        levels("window");
        chk("lit npix", 32'(px_log.size()), 4);
        if (px_log.size() >= 4) begin
            chk("lit p0", {px_log[0].x[7:0], px_log[0].y[7:0], px_log[0].d}, 32'h0A05F800);
            chk("lit p1", {px_log[1].x[7:0], px_log[1].y[7:0], px_log[1].d}, 32'h0B05FFE0);
            chk("lit p2", {px_log[2].x[7:0], px_log[2].y[7:0], px_log[2].d}, 32'h0A0607E0);
            chk("lit p3", {px_log[3].x[7:0], px_log[3].y[7:0], px_log[3].d}, 32'h0B06001F);
            chk("lit fd", {px_log[0].fd, px_log[1].fd, px_log[2].fd, px_log[3].fd}, 32'h1);
        end
`ifdef LCD_RX_PIXCNT_EN
        chk("lit pix_count", 32'(pix_count), 4);
`endif

        // wrap back to window origin
        send_byte(1, 8'h12); send_byte(1, 8'h34);
        chk("lit npix wrap", 32'(px_log.size()), 5);
        if (px_log.size() >= 5)
            chk("lit wrap", {px_log[4].x[7:0], px_log[4].y[7:0], px_log[4].d}, 32'h0A051234);

        // leave RAMWR, partial byte dropped, then data in IDLE
        send_byte(0, 8'h00);
        np = px_log.size();
        send_bits(1, 8'hFF, 5);
        repeat (4) @(negedge clk);
        lcd_sel = 1'b1;
        repeat (8) @(negedge clk);
        send_byte(1, 8'hA5);
        chk("lit idle byte", 32'(by_log[by_log.size()-1]), 32'h0A5);
        chk("lit idle nopix", 32'(px_log.size()), 32'(np));
        chk("lit err before odd", 32'(err_flag), 0);
        levels("idle");

        // odd number of pixel bytes then a command
        send_byte(0, 8'h2C);
        send_byte(1, 8'h11); send_byte(1, 8'h22); send_byte(1, 8'h33);
        send_byte(0, 8'h00);
        chk("lit odd npix", 32'(px_log.size()), 32'(np + 1));
        chk("lit odd err", 32'(err_flag), 1);
        levels("odd");

        // invalid column window
        do_reset();
        send_byte(0, 8'h2A);
        send_byte(1, 8'h00); send_byte(1, 8'hF0); send_byte(1, 8'h00); send_byte(1, 8'hF5);
        np = px_log.size();
        send_byte(0, 8'h2C);
        send_byte(1, 8'hAB); send_byte(1, 8'hCD);
        chk("lit badwin err", 32'(err_flag), 1);
        chk("lit badwin nopix", 32'(px_log.size()), 32'(np));
        levels("badwin");

        // asynchronous reset in the middle of a pixel stream
        do_reset();
        send_byte(0, 8'h11);
        send_byte(0, 8'h2C);
        send_byte(1, 8'h55); send_byte(1, 8'hAA);
        send_byte(1, 8'h77);
        send_bits(1, 8'hF0, 4);
        chk("lit pre-rst pix", 32'(pix_data), 32'h55AA);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 all_zero("async rst");
        model_reset();
        repeat (3) @(negedge clk);
        lcd_sel = 1'b1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        np = px_log.size();
        send_byte(1, 8'h12); send_byte(1, 8'h34);
        chk("lit post-rst nopix", 32'(px_log.size()), 32'(np));
        send_byte(0, 8'h2C);
        send_byte(1, 8'h9A); send_byte(1, 8'hBC);
        chk("lit post-rst npix", 32'(px_log.size()), 32'(np + 1));
        if (px_log.size() == np + 1)
            chk("lit post-rst pix", {px_log[np].x[7:0], px_log[np].y[7:0], px_log[np].d}, 32'h00009ABC);
        levels("post-rst");

        repeat (20) @(negedge clk);
        chk("bytes drained", 32'(exp_b.size()), 0);
        chk("pixels drained", 32'(exp_p.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
